cms_trace_receiver: RTL
=======================

# cms_trace_receiver

AXI-Stream slave that terminates the trace stream produced by `continuous_monitoring_system`. It accepts each packed trace item, buffers it in a small FIFO, and unpacks it into PC, instruction, clock-counter delta and performance-event counter fields. It reconstructs an absolute clock count from the deltas and checks `tlast` framing against the programmed interval. It sits on the host/analysis side of the stream, in place of the DMA FIFO, and is used for on-chip consumers and as the bench-side model of the sink.

## Interface
Parameters:
- `XLEN`, 64, PC width.
- `AXI_DATA_WIDTH`, package `AXI_DATA_WIDTH`, stream beat width.
- `FIFO_DEPTH`, 4, item buffer depth; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `S_AXIS_tvalid`  in  1  beat valid.
- `S_AXIS_tready`  out  1  beat accepted when high together with `tvalid`.
- `S_AXIS_tdata`  in  `AXI_DATA_WIDTH`  packed trace item.
- `S_AXIS_tlast`  in  1  end-of-frame marker.
- `tlast_interval`  in  32  expected beats per frame; 0 disables the framing check.
- `out_valid`  out  1  decoded item available.
- `out_ready`  in  1  consumer pops the item.
- `out_pc`  out  `XLEN`  item PC.
- `out_instr`  out  32  item instruction.
- `out_clk_delta`  out  `CLK_COUNTER_WIDTH`  raw delta field.
- `out_clk_abs`  out  64  reconstructed absolute clock count.
- `out_perf_counters`  out  `NO_OF_PERFORMANCE_EVENTS*PERFORMANCE_EVENT_MOD_COUNTER_WIDTH`  raw counter field.
- `out_last`  out  1  `tlast` captured with the item.
- `out_frame_index`  out  32  beat index of the item within its frame.
- `framing_error`  out  1  sticky error flag.
- `error_count`  out  16  saturating count of framing errors.
- `clear_error`  in  1  clears `framing_error` and `error_count`.

## Operation
- Field offsets: counters at bit 0, `PC_LOCATION = N*W`, `CLK_COUNTER_DELTA_LOCATION = PC_LOCATION+XLEN`, `INSTR_LOCATION = CLK_COUNTER_DELTA_LOCATION+CLK_COUNTER_WIDTH`. Bits above the instruction field are ignored.
- Accept rule: `S_AXIS_tready = (count != FIFO_DEPTH)`. It is a registered function of the occupancy. When the FIFO is full, no push occurs even if a pop happens in the same cycle.
- On accept:
  - `clk_acc <= clk_acc + delta` (64-bit, wraps modulo 2^64, delta zero-extended).
  - The stored `out_clk_abs` is the post-add value, so the first item after reset reports `abs = delta`.
- Frame tracking uses `beat_idx` (32-bit), which is stored with each item as `out_frame_index`.
  - With `tlast_interval != 0`, an error occurs when `tlast` arrives while `beat_idx != tlast_interval-1`, or when `tlast` is absent at `beat_idx == tlast_interval-1`.
  - After any accepted beat, `beat_idx` returns to 0 if `tlast` is set or `beat_idx == tlast_interval-1`; otherwise it increments.
  - With `tlast_interval == 0`: no errors are raised, `beat_idx` resets only on `tlast`, and it saturates at 2^32-1.
- Error flag: an error sets `framing_error` and increments `error_count`, saturating at 0xFFFF. If `clear_error` and a new error occur in the same cycle, the result is flag = 1 and count = 1.
- Output and pop: the head entry drives all `out_*` fields directly from FIFO storage. A pop occurs on `out_valid && out_ready`. A push and a pop in the same cycle leave `count` unchanged.
- Data items (stall cycles or repeated PCs) are never dropped or merged; every accepted beat yields exactly one output item.

## Timing
- Reset values: `S_AXIS_tready=1` (FIFO empty), `out_valid=0`, `out_*` data = 0, `framing_error=0`, `error_count=0`, `clk_acc=0`, `beat_idx=0`.
- Reset asserted mid-operation empties the FIFO and discards buffered items.
- Latency: a beat accepted at edge k gives `out_valid=1` after edge k. There is no combinational path from `S_AXIS_*` to `out_*` or to `S_AXIS_tready`.
- `framing_error` rises after the edge that accepts the offending beat.
- Throughput: one item per cycle sustained while `out_ready=1`.
- `out_*` fields are stable while `out_valid && !out_ready`.

## Structure
- `continuous_monitoring_system_pkg` gains `PC_LOCATION`, `CLK_COUNTER_DELTA_LOCATION` and `INSTR_LOCATION`, plus a `cms_trace_item_t` packed struct, shared with the transmitter so both ends use one layout.
- Sub-module `cms_sync_fifo`: generic registered-occupancy FIFO parameterised on width and depth, holding `{tlast, frame_index, clk_abs, raw fields}`.

## Test plan
- **Single beat:** reset, then one beat with pc=0x8, instr=0x0000006f, delta=3 → `out_pc=0x8`, `out_instr=0x6f`, `out_clk_abs=3`, `out_frame_index=0` one cycle after accept.
- **Delta accumulation:** deltas 3, 1, 5 → `out_clk_abs` = 3, 4, 9.
- **Delta wrap:** preload to accumulate to 2^64-2, then delta 5 → `out_clk_abs` = 3.
- **Back-pressure:** hold `out_ready=0` with continuous `tvalid` → exactly 4 beats accepted and `tready=0`. Then raise `out_ready` → items pop in order with none lost or duplicated.
- **Framing:**
  - `tlast_interval=3` with `tlast` on beats 2 and 5 → no error.
  - `tlast` on beat 1 → `framing_error=1`, `error_count=1`, and the next beat has index 0.
  - Missing `tlast` on beat 2 → `error_count=2`.
- **Clear and reset:**
  - `clear_error` coincident with a new error → flag = 1, count = 1.
  - `rst` asserted with 3 items buffered → `out_valid=0` and `tready=1` immediately, with no clock edge required.

Source files
------------

// File: rtl/continuous_monitoring_system_pkg.sv
// Shared trace-item layout for the continuous monitoring transmitter and its receiver.
package continuous_monitoring_system_pkg;

    localparam int unsigned XLEN                                = 64;
    localparam int unsigned CLK_COUNTER_WIDTH                   = 64;
    localparam int unsigned NO_OF_PERFORMANCE_EVENTS            = 4;
    localparam int unsigned PERFORMANCE_EVENT_MOD_COUNTER_WIDTH = 8;
    localparam int unsigned PERF_WIDTH =
        NO_OF_PERFORMANCE_EVENTS * PERFORMANCE_EVENT_MOD_COUNTER_WIDTH;

    localparam int unsigned PC_LOCATION                = PERF_WIDTH;
    localparam int unsigned CLK_COUNTER_DELTA_LOCATION = PC_LOCATION + XLEN;
    localparam int unsigned INSTR_LOCATION             = CLK_COUNTER_DELTA_LOCATION + CLK_COUNTER_WIDTH;
    localparam int unsigned TRACE_ITEM_WIDTH           = INSTR_LOCATION + 32;
    localparam int unsigned AXI_DATA_WIDTH             = TRACE_ITEM_WIDTH;

    // Last member sits at bit 0, so member order mirrors the *_LOCATION offsets.
    typedef struct packed {
        logic [31:0]                  instr;
        logic [CLK_COUNTER_WIDTH-1:0] clk_delta;
        logic [XLEN-1:0]              pc;
        logic [PERF_WIDTH-1:0]        perf_counters;
    } cms_trace_item_t;

endpackage

// File: rtl/cms_sync_fifo.sv
// Synchronous FIFO whose ready/valid flags are flops updated from the next occupancy.
module cms_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    input  logic             pop_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             not_full_q, not_full_d;
    logic             not_empty_q, not_empty_d;
    logic             push_c, pop_c;

    // A full FIFO refuses the push even when the head is popped in the same cycle.
    always_comb begin
        push_c      = push_valid && not_full_q;
        pop_c       = pop_ready && not_empty_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        not_full_d  = (count_d != CW'(DEPTH));
        not_empty_d = (count_d != CW'(0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            not_full_q  <= 1'b1;
            not_empty_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            not_full_q  <= not_full_d;
            not_empty_q <= not_empty_d;
        end
    end

    assign push_ready = not_full_q;
    assign pop_valid  = not_empty_q;
    assign pop_data   = mem_q[rd_ptr_q];

endmodule

// File: rtl/cms_trace_receiver.sv
// AXI-Stream sink for the monitoring trace: buffers items, rebuilds absolute
// clock counts from deltas and checks tlast framing against a programmed interval.
module cms_trace_receiver
    import continuous_monitoring_system_pkg::*;
#(
    parameter int unsigned XLEN           = continuous_monitoring_system_pkg::XLEN,
    parameter int unsigned AXI_DATA_WIDTH = continuous_monitoring_system_pkg::AXI_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         S_AXIS_tvalid,
    output logic                         S_AXIS_tready,
    input  logic [AXI_DATA_WIDTH-1:0]    S_AXIS_tdata,
    input  logic                         S_AXIS_tlast,
    input  logic [31:0]                  tlast_interval,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_pc,
    output logic [31:0]                  out_instr,
    output logic [CLK_COUNTER_WIDTH-1:0] out_clk_delta,
    output logic [63:0]                  out_clk_abs,
    output logic [PERF_WIDTH-1:0]        out_perf_counters,
    output logic                         out_last,
    output logic [31:0]                  out_frame_index,
    output logic                         framing_error,
    output logic [15:0]                  error_count,
    input  logic                         clear_error
);

    localparam int unsigned PC_LOC    = PERF_WIDTH;
    localparam int unsigned DELTA_LOC = PC_LOC + XLEN;
    localparam int unsigned INSTR_LOC = DELTA_LOC + CLK_COUNTER_WIDTH;
    localparam int unsigned ITEM_W    = INSTR_LOC + 32;
    localparam int unsigned ABS_LOC   = ITEM_W;
    localparam int unsigned IDX_LOC   = ABS_LOC + 64;
    localparam int unsigned ENTRY_W   = IDX_LOC + 32 + 1;

    logic [63:0]          clk_acc_q, clk_acc_d;
    logic [31:0]          beat_idx_q, beat_idx_d;
    logic                 framing_error_q, framing_error_d;
    logic [15:0]          error_count_q, error_count_d;
    logic                 accept_c, framing_on_c, last_beat_c, frame_err_c;
    logic [ENTRY_W-1:0]   push_entry_c, head_c;

    if (AXI_DATA_WIDTH > ITEM_W) begin : g_hi_bits
        logic unused_hi_c;
        assign unused_hi_c = ^S_AXIS_tdata[AXI_DATA_WIDTH-1:ITEM_W];
    end

    always_comb begin
        clk_acc_d       = clk_acc_q;
        beat_idx_d      = beat_idx_q;
        framing_error_d = framing_error_q;
        error_count_d   = error_count_q;

        accept_c     = S_AXIS_tvalid && S_AXIS_tready;
        framing_on_c = (tlast_interval != 32'd0);
        last_beat_c  = (beat_idx_q == tlast_interval - 32'd1);
        frame_err_c  = accept_c && framing_on_c && (S_AXIS_tlast != last_beat_c);

        if (accept_c) begin
            clk_acc_d = clk_acc_q + 64'(S_AXIS_tdata[DELTA_LOC +: CLK_COUNTER_WIDTH]);
            if (S_AXIS_tlast || (framing_on_c && last_beat_c)) begin
                beat_idx_d = 32'd0;
            end else if (beat_idx_q != 32'hFFFF_FFFF) begin
                beat_idx_d = beat_idx_q + 32'd1;
            end
        end

        // A clear coincident with a fresh error leaves exactly that one error recorded.
        if (clear_error) begin
            framing_error_d = frame_err_c;
            error_count_d   = frame_err_c ? 16'd1 : 16'd0;
        end else if (frame_err_c) begin
            framing_error_d = 1'b1;
            if (error_count_q != 16'hFFFF) begin
                error_count_d = error_count_q + 16'd1;
            end
        end

        push_entry_c = {S_AXIS_tlast, beat_idx_q, clk_acc_d, S_AXIS_tdata[ITEM_W-1:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_acc_q       <= '0;
            beat_idx_q      <= '0;
            framing_error_q <= 1'b0;
            error_count_q   <= '0;
        end else begin
            clk_acc_q       <= clk_acc_d;
            beat_idx_q      <= beat_idx_d;
            framing_error_q <= framing_error_d;
            error_count_q   <= error_count_d;
        end
    end

    cms_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (S_AXIS_tvalid),
        .push_data  (push_entry_c),
        .push_ready (S_AXIS_tready),
        .pop_ready  (out_ready),
        .pop_valid  (out_valid),
        .pop_data   (head_c)
    );

    assign out_perf_counters = head_c[0 +: PERF_WIDTH];
    assign out_pc            = head_c[PC_LOC +: XLEN];
    assign out_clk_delta     = head_c[DELTA_LOC +: CLK_COUNTER_WIDTH];
    assign out_instr         = head_c[INSTR_LOC +: 32];
    assign out_clk_abs       = head_c[ABS_LOC +: 64];
    assign out_frame_index   = head_c[IDX_LOC +: 32];
    assign out_last          = head_c[ENTRY_W-1];
    assign framing_error     = framing_error_q;
    assign error_count       = error_count_q;

endmodule
